dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter (core vs loader) onto one synchronous RAM port
// Round-robin with a bounded loader bus lock; read data returns one cycle after grant.
module dmem_arbiter (
  input  logic        clk,
  input  logic        nrst,
  input  logic        c_req,
  input  logic [7:0]  c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_wr,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_lock,
  input  logic [7:0]  l_addr,
  input  logic [31:0] l_wdata,
  input  logic [3:0]  l_wr,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        m_en,
  output logic [7:0]  m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wr,
  input  logic [31:0] m_rdata,
  output logic        stall
);

  localparam logic [3:0] LOCK_MAX = 4'd15;

  logic       last_gnt_q, last_gnt_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       l_won_q, l_won_d;
  logic       c_rv_q, c_rv_d;
  logic       l_rv_q, l_rv_d;
  logic       lock_expired;
  logic       lock_hold;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_gnt_q <= 1'b1;
      lock_cnt_q <= 4'd0;
      l_won_q    <= 1'b0;
      c_rv_q     <= 1'b0;
      l_rv_q     <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      l_won_q    <= l_won_d;
      c_rv_q     <= c_rv_d;
      l_rv_q     <= l_rv_d;
    end
  end

  // Lock only extends an unbroken loader ownership; after 15 locked grants the core gets through.
  always_comb begin
    c_gnt        = 1'b0;
    l_gnt        = 1'b0;
    lock_expired = (lock_cnt_q == LOCK_MAX);
    lock_hold    = l_lock & l_won_q & ~lock_expired;
    if (nrst) begin
      if (c_req && l_req) begin
        if (lock_hold) begin
          l_gnt = 1'b1;
        end else if (lock_expired || last_gnt_q) begin
          c_gnt = 1'b1;
        end else begin
          l_gnt = 1'b1;
        end
      end else begin
        c_gnt = c_req;
        l_gnt = l_req;
      end
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    lock_cnt_d = 4'd0;
    l_won_d    = l_gnt;
    c_rv_d     = c_gnt & ~(|c_wr);
    l_rv_d     = l_gnt & ~(|l_wr);
    if (c_gnt) begin
      last_gnt_d = 1'b0;
    end else if (l_gnt) begin
      last_gnt_d = 1'b1;
    end
    if (l_gnt && l_lock) begin
      lock_cnt_d = lock_expired ? LOCK_MAX : lock_cnt_q + 4'd1;
    end
  end

  always_comb begin
    m_en    = c_gnt | l_gnt;
    m_addr  = 8'd0;
    m_wdata = 32'd0;
    m_wr    = 4'd0;
    if (c_gnt) begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_wr    = c_wr;
    end else if (l_gnt) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
      m_wr    = l_wr;
    end
  end

  assign stall    = nrst & c_req & ~c_gnt;
  assign c_rvalid = c_rv_q;
  assign l_rvalid = l_rv_q;
  assign c_rdata  = c_rv_q ? m_rdata : 32'd0;
  assign l_rdata  = l_rv_q ? m_rdata : 32'd0;

endmodule
